demux14: RTL
============

# demux14

Registered 1-to-4 distributor: accepts one W-bit word per transfer on a valid/ready input and steers it into one of four output holding registers, picked by a 2-bit select. Each output channel has its own valid flag and acknowledge, so four independent consumers can drain at their own pace. It is the write-side counterpart of the 4-to-1 selector: the selector merges four buses onto one, this block fans one bus out to four, with flow control.

## Interface
- W, default 4: data width of input and each output channel.

- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iD  in  W  input data word.
- iValid  in  1  iD is offered this cycle.
- oReady  out  1  target channel can take a word this cycle (combinational).
- iS1  in  1  select, MSB.
- iS0  in  1  select, LSB; target channel n = {iS1,iS0}.
- iAuto  in  1  round-robin steering request (used only when DEMUX_RR_EN is defined).
- iAck  in  4  iAck[n] = consumer n takes oZn this cycle.
- oZ0, oZ1, oZ2, oZ3  out  W  channel holding registers.
- oV  out  4  oV[n] = oZn holds an unconsumed word.
- oPtr  out  2  round-robin pointer (constant 0 without DEMUX_RR_EN).

## Operation
- Target t:
  - t = {iS1,iS0}, unless auto mode is active.
  - Auto mode (macro defined and iAuto=1): t = oPtr.
- Ready: oReady = ~oV[t] | iAck[t]. The same-cycle ack frees the slot (pass-through), so a full, acked channel accepts back-to-back.
- Accept: iValid & oReady at an edge.
  - oZt <= iD and oV[t] <= 1.
  - Other channels are unaffected except by their own ack.
- Consume: iAck[n] & oV[n] at an edge.
  - Clears oV[n] unless channel n is written in that same cycle.
  - If written in that cycle, oV[n] stays 1 and oZn takes the new word.
- Ack with oV[n]=0 is ignored.
- oZn keeps its last value after consume and changes only on a write or reset.
- iValid with oReady=0: nothing is written and no state changes. The producer must hold iD and the select until accepted.
- Select change while iValid is stalled: allowed. The new t is evaluated fresh each cycle.
- Round-robin pointer (macro defined):
  - oPtr <= oPtr+1 mod 4 on each accept made in auto mode.
  - It wraps 3 -> 0.
  - An accept in manual mode (iAuto=0) does not move oPtr.
  - A stall does not move oPtr.
- Output channels never reorder: each channel holds at most one word.

## Timing
- Reset values: oZ0..oZ3 = 0, oV = 4'b0000, oPtr = 0, so oReady = 1 after reset.
- Reset mid-operation discards all held words at that edge. Any accept or ack in the reset cycle is ignored.
- Latency: a word accepted at edge k is visible on oZt with oV[t]=1 immediately after edge k (1 cycle).
- Throughput: 1 word per cycle when the target is empty or acked in the same cycle.
- oReady depends combinationally on iS1, iS0, iAuto, oV and iAck. No combinational path from iValid or iD to any output.
- Simultaneous acks on several channels are all honoured in one edge.

## Configuration
- DEMUX_RR_EN defined: round-robin auto-steering is compiled in. The oPtr register exists, and iAuto=1 overrides iS1/iS0.
- DEMUX_RR_EN undefined:
  - iAuto is ignored and the steering is always {iS1,iS0}.
  - oPtr is tied to 2'b00.
  - No pointer register is built.

## Test plan
- Reset: drive iRst=1 for 2 cycles with iValid=1, iD=4'hF. Required: oV=0000, oZ0..3=0, oPtr=0; release and check oReady=1.
- Manual steering: S=00,01,10,11 with iD=1,2,3,4, one per cycle, no acks. Required: oZ0..3=1,2,3,4, oV=1111 after 4 edges; a fifth offer to S=10 sees oReady=0, and oZ2 stays 3.
- Pass-through: with oV[2]=1 and oZ2=3, drive S=10, iD=9, iValid=1, iAck[2]=1 in one cycle. Required: oReady=1; after the edge oZ2=9 and oV[2]=1.
- Ack only: iAck=0101 with no iValid on the full set. Required: oV=1010; oZ0/oZ2 values unchanged; iAck[0] again has no effect.
- Round-robin (macro on): iAuto=1, 6 words A..F each accepted, with S held at 11. Required: channels 0,1,2,3 get A,B,C,D; E stalls on channel 0 until ack[0], then oPtr 0->1; oPtr wraps 3->0.
- Macro off: the same stimulus as round-robin. Required: every word targets channel 3, only A is accepted until acked, and oPtr stays 0.

Source files
------------

// File: rtl/demux14.sv
// demux14: registered 1-to-4 distributor with per-channel valid/ack.
// Define DEMUX_RR_EN to build round-robin auto-steering (oPtr, iAuto).
module demux14 #(
    parameter int W = 4
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [W-1:0] iD,
    input  logic         iValid,
    output logic         oReady,
    input  logic         iS1,
    input  logic         iS0,
    input  logic         iAuto,
    input  logic [3:0]   iAck,
    output logic [W-1:0] oZ0,
    output logic [W-1:0] oZ1,
    output logic [W-1:0] oZ2,
    output logic [W-1:0] oZ3,
    output logic [3:0]   oV,
    output logic [1:0]   oPtr
);

    logic [W-1:0] z_q [4];
    logic [3:0]   v_q;
    logic [1:0]   tgt;
    logic [3:0]   tgt_hot;
    logic [3:0]   wr;
    logic         accept;

`ifdef DEMUX_RR_EN
    logic [1:0] ptr_q;

    always_comb begin
        tgt = {iS1, iS0};
        if (iAuto) begin
            tgt = ptr_q;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ptr_q <= 2'b00;
        end else if (accept && iAuto) begin
            ptr_q <= ptr_q + 2'd1;
        end
    end

    assign oPtr = ptr_q;
`else
    logic unused_auto;

    assign unused_auto = iAuto;
    assign tgt         = {iS1, iS0};
    assign oPtr        = 2'b00;
`endif

    // A same-cycle ack frees the target slot, allowing back-to-back writes.
    always_comb begin
        tgt_hot = 4'b0000;
        tgt_hot[tgt] = 1'b1;
    end

    assign oReady = ~v_q[tgt] | iAck[tgt];
    assign accept = iValid & oReady;
    assign wr     = tgt_hot & {4{accept}};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int n = 0; n < 4; n++) begin
                z_q[n] <= '0;
            end
            v_q <= 4'b0000;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (wr[n]) begin
                    z_q[n] <= iD;
                end
            end
            v_q <= wr | (v_q & ~iAck);
        end
    end

    assign oZ0 = z_q[0];
    assign oZ1 = z_q[1];
    assign oZ2 = z_q[2];
    assign oZ3 = z_q[3];
    assign oV  = v_q;

endmodule
